// File: rtl/piezo_event_sequencer.sv
// rtl/piezo_event_sequencer.sv - fixed-priority piezo pattern scheduler with pre-emption
module piezo_event_sequencer #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned NOTE_MS = 100,
    parameter int unsigned GAP_MS  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1ms,
    input  logic [3:0] req,
    input  logic       cancel,
    output logic [3:0] ack,
    output logic       busy,
    output logic [1:0] active_id,
    output logic       piezo
);

    typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

    localparam logic [31:0] H_C6 = 32'(CLK_HZ / (2 * 1047));
    localparam logic [31:0] H_C5 = 32'(CLK_HZ / (2 * 523));
    localparam logic [31:0] H_E5 = 32'(CLK_HZ / (2 * 659));
    localparam logic [31:0] H_G5 = 32'(CLK_HZ / (2 * 784));
    localparam logic [31:0] H_G4 = 32'(CLK_HZ / (2 * 392));
    localparam logic [31:0] H_C4 = 32'(CLK_HZ / (2 * 262));
    localparam logic [31:0] H_A5 = 32'(CLK_HZ / (2 * 880));

    localparam logic [15:0] NOTE_LAST = 16'(NOTE_MS - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_MS - 1);

    // Tone half-period for a given pattern and note index
    function automatic logic [31:0] half_of(input logic [1:0] id, input logic [1:0] n);
        case (id)
            2'd0:    half_of = H_C6;
            2'd1:    half_of = (n == 2'd0) ? H_C5 : ((n == 2'd1) ? H_E5 : H_G5);
            2'd2:    half_of = (n == 2'd0) ? H_G4 : H_C4;
            default: half_of = (n == 2'd0) ? H_A5 : H_E5;
        endcase
    endfunction

    // Index of the final note of each pattern
    function automatic logic [1:0] last_note(input logic [1:0] id);
        case (id)
            2'd0:    last_note = 2'd0;
            2'd1:    last_note = 2'd2;
            default: last_note = 2'd1;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  pat_q, pat_d;
    logic [1:0]  note_q, note_d;
    logic [31:0] half_cnt_q, half_cnt_d;
    logic [15:0] ms_cnt_q, ms_cnt_d;
    logic        piezo_q, piezo_d;
    logic [3:0]  pending_q, pending_d;
    logic [3:0]  ack_q, ack_d;

    logic [3:0]  pend_eff;
    logic [1:0]  hi_id;
    logic        hi_valid;

    // Merge new requests with latched ones (cancel suppresses alarm) and pick the highest
    always_comb begin
        pend_eff = pending_q | req;
        if (cancel) begin
            pend_eff[3] = 1'b0;
        end
        hi_valid = |pend_eff;
        hi_id    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (pend_eff[i]) begin
                hi_id = 2'(i);
            end
        end
    end

    // Next-state: cancel, accept/pre-empt, then note/gap timing
    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        note_d     = note_q;
        half_cnt_d = half_cnt_q;
        ms_cnt_d   = ms_cnt_q;
        piezo_d    = piezo_q;
        pending_d  = pend_eff;
        ack_d      = 4'b0000;

        if (cancel && (state_q != IDLE) && (pat_q == 2'd3)) begin
            state_d = IDLE;
            piezo_d = 1'b0;
        end else if (hi_valid && ((state_q == IDLE) || (hi_id > pat_q))) begin
            pending_d[hi_id] = 1'b0;
            ack_d            = 4'b0001 << hi_id;
            state_d          = NOTE;
            pat_d            = hi_id;
            note_d           = 2'd0;
            half_cnt_d       = 32'd0;
            ms_cnt_d         = 16'd0;
            piezo_d          = 1'b0;
        end else begin
            case (state_q)
                NOTE: begin
                    if (half_cnt_q == half_of(pat_q, note_q) - 32'd1) begin
                        half_cnt_d = 32'd0;
                        piezo_d    = ~piezo_q;
                    end else begin
                        half_cnt_d = half_cnt_q + 32'd1;
                    end
                    if (tick_1ms) begin
                        if (ms_cnt_q == NOTE_LAST) begin
                            state_d    = GAP;
                            ms_cnt_d   = 16'd0;
                            half_cnt_d = 32'd0;
                            piezo_d    = 1'b0;
                        end else begin
                            ms_cnt_d = ms_cnt_q + 16'd1;
                        end
                    end
                end
                GAP: begin
                    piezo_d = 1'b0;
                    if (tick_1ms) begin
                        if (ms_cnt_q == GAP_LAST) begin
                            ms_cnt_d   = 16'd0;
                            half_cnt_d = 32'd0;
                            if (note_q != last_note(pat_q)) begin
                                note_d  = note_q + 2'd1;
                                state_d = NOTE;
                            end else if (pat_q == 2'd3) begin
                                note_d  = 2'd0;
                                state_d = NOTE;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            ms_cnt_d = ms_cnt_q + 16'd1;
                        end
                    end
                end
                default: begin
                    piezo_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pat_q      <= 2'd0;
            note_q     <= 2'd0;
            half_cnt_q <= 32'd0;
            ms_cnt_q   <= 16'd0;
            piezo_q    <= 1'b0;
            pending_q  <= 4'd0;
            ack_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            note_q     <= note_d;
            half_cnt_q <= half_cnt_d;
            ms_cnt_q   <= ms_cnt_d;
            piezo_q    <= piezo_d;
            pending_q  <= pending_d;
            ack_q      <= ack_d;
        end
    end

    assign ack       = ack_q;
    assign busy      = (state_q != IDLE);
    assign active_id = pat_q;
    assign piezo     = piezo_q;

endmodule

// File: tb/tb_piezo_event_sequencer.sv
// tb/tb_piezo_event_sequencer.sv - scoreboard bench for piezo_event_sequencer
module tb_piezo_event_sequencer;

    localparam int CLK_HZ  = 1_000_000;
    localparam int NOTE_MS = 20;
    localparam int GAP_MS  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1ms = 1'b0;
    logic [3:0] req = 4'h0;
    logic       cancel = 1'b0;
    logic [3:0] ack;
    logic       busy;
    logic [1:0] active_id;
    logic       piezo;

    piezo_event_sequencer #(
        .CLK_HZ (CLK_HZ),
        .NOTE_MS(NOTE_MS),
        .GAP_MS (GAP_MS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1ms (tick_1ms),
        .req      (req),
        .cancel   (cancel),
        .ack      (ack),
        .busy     (busy),
        .active_id(active_id),
        .piezo    (piezo)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int nprint = 0;

    logic [7:0] exp_q[$];
    int         ack_q[$];

    // reference model state: which pattern, which note, note or gap, when the phase began
    bit [3:0] m_pend = 4'h0;
    bit       m_busy = 1'b0;
    bit       m_gap = 1'b0;
    int       m_pat = 0;
    int       m_note = 0;
    int       m_start = 0;
    int       m_str = 0;
    int       cyc = 0;

    function automatic int half_for(input int p, input int n);
        int f;
        case (p)
            0:       f = 1047;
            1:       f = (n == 0) ? 523 : ((n == 1) ? 659 : 784);
            2:       f = (n == 0) ? 392 : 262;
            default: f = (n == 0) ? 880 : 659;
        endcase
        return CLK_HZ / (2 * f);
    endfunction

    function automatic int notes_in(input int p);
        case (p)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    task automatic note_fail(input string what, input int got, input int want);
        bad++;
        if (nprint < 30) begin
            $display("FAIL %s cyc=%0d got=%0h want=%0h", what, cyc, got, want);
            nprint++;
        end
    endtask

    // reference model: evaluates the behavioural rules once per clock
    always @(posedge clk) begin
        bit [3:0] pe;
        bit [3:0] m_ack;
        int       hi;
        bit       pz;
        cyc++;
        m_ack = 4'h0;
        if (rst) begin
            m_pend = 4'h0;
            m_busy = 1'b0;
            m_gap  = 1'b0;
            m_pat  = 0;
            m_note = 0;
        end else begin
            pe = m_pend | req;
            if (cancel) pe[3] = 1'b0;
            hi = -1;
            for (int i = 0; i < 4; i++) if (pe[i]) hi = i;
            if (cancel && m_busy && m_pat == 3) begin
                m_busy = 1'b0;
            end else if (hi >= 0 && (!m_busy || hi > m_pat)) begin
                pe[hi]    = 1'b0;
                m_ack[hi] = 1'b1;
                ack_q.push_back(hi);
                m_busy  = 1'b1;
                m_pat   = hi;
                m_note  = 0;
                m_gap   = 1'b0;
                m_start = cyc;
                m_str   = 0;
            end else if (m_busy && tick_1ms) begin
                m_str++;
                if (!m_gap && m_str == NOTE_MS) begin
                    m_gap = 1'b1;
                    m_str = 0;
                end else if (m_gap && m_str == GAP_MS) begin
                    m_str   = 0;
                    m_gap   = 1'b0;
                    m_start = cyc;
                    if (m_note + 1 < notes_in(m_pat)) m_note++;
                    else if (m_pat == 3) m_note = 0;
                    else m_busy = 1'b0;
                end
            end
            m_pend = pe;
        end
        pz = (m_busy && !m_gap) ? (((cyc - m_start) / half_for(m_pat, m_note)) % 2 == 1) : 1'b0;
        exp_q.push_back({m_ack, m_busy, 2'(m_pat), pz});
    end

    // monitor: pops expectations as the DUT presents each cycle's outputs and each ack
    always @(negedge clk) begin
        logic [7:0] e;
        logic [7:0] got;
        int         want_id;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {ack, busy, active_id, piezo};
            total++;
            if (got !== e) note_fail("status{ack,busy,id,piezo}", int'(got), int'(e));
            if (ack !== 4'h0) begin
                total++;
                if (ack_q.size() == 0) begin
                    note_fail("ack_unexpected", int'(ack), 0);
                end else begin
                    want_id = ack_q.pop_front();
                    if (ack !== (4'b0001 << want_id)) note_fail("ack_id", int'(ack), 1 << want_id);
                end
            end
        end
    end

    // 1 kHz strobe stand-in with randomized spacing
    initial begin
        forever begin
            repeat ($urandom_range(40, 80)) @(posedge clk);
            #1 tick_1ms = 1'b1;
            @(posedge clk);
            #1 tick_1ms = 1'b0;
        end
    end

    task automatic pulse(input logic [3:0] r, input logic c);
        @(posedge clk);
        #1;
        req    = r;
        cancel = c;
        @(posedge clk);
        #1;
        req    = 4'h0;
        cancel = 1'b0;
    endtask

    task automatic wait_strobes(input int n);
        repeat (n) begin
            do @(posedge clk); while (!tick_1ms);
        end
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= budget) begin
            total++;
            note_fail("idle_timeout", n, budget);
        end
    endtask

    task automatic drain();
        wait_idle(40000);
        repeat (3) @(posedge clk);
        #1;
        wait_idle(40000);
    endtask

    initial begin
        // reset held with all requests asserted
        rst = 1'b1;
        req = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        req = 4'h0;
        repeat (20) @(posedge clk);
        #1;

        // single key beep
        pulse(4'b0001, 1'b0);
        drain();

        // success pre-empts key beep after 10 strobes
        pulse(4'b0001, 1'b0);
        wait_strobes(10);
        pulse(4'b0010, 1'b0);
        drain();

        // key beep waits behind success
        pulse(4'b0010, 1'b0);
        wait_strobes($urandom_range(5, 60));
        pulse(4'b0001, 1'b0);
        drain();

        // alarm for several cycles, cancel, then req+cancel together
        pulse(4'b1000, 1'b0);
        wait_strobes(3 * 2 * (NOTE_MS + GAP_MS) + $urandom_range(1, 10));
        pulse(4'b0000, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        pulse(4'b1000, 1'b1);
        repeat (20) @(posedge clk);
        #1;

        // fail re-requested during its second note, then reset mid-pattern
        pulse(4'b0100, 1'b0);
        wait_strobes(NOTE_MS + GAP_MS + 5);
        pulse(4'b0100, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (200) @(posedge clk);
        #1;

        // randomized request/cancel traffic
        repeat (30) begin
            logic [3:0] r;
            logic       c;
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) r = r & 4'b0111;
            c = ($urandom_range(0, 5) == 0);
            pulse(r, c);
            repeat ($urandom_range(1, 1500)) @(posedge clk);
            #1;
        end
        pulse(4'b0000, 1'b1);
        drain();
        repeat (10) @(posedge clk);
        #1;

        total++;
        if (ack_q.size() != 0) note_fail("ack_missing", 0, ack_q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
